crc_msg_packer: RTL and testbench
=================================

Name: crc_msg_packer

Overview:
- Upstream feeder for the 256-bit CRC32 checker.
- Accepts a byte stream with valid/ready/last handshake.
- Packs bytes little-endian into 32-bit words. Emits exactly WORDS_PER_MSG words per message, zero-padded, with last flagged on the final word.
- Inserts an idle gap after each message so the checker's capture/compute/output pipeline drains before the next message starts.

Parameters:
- WORDS_PER_MSG, 8: words emitted per message (checker block size / 32).
- GAP_CYCLES, 3: idle cycles forced after each last word, with s_ready_o held low. 0 is allowed.
- PAD_BYTE, 8'h00: fill value for unused byte lanes and pad words.

Ports:
- clk_i  in  1  system clock (200 MHz).
- rst_i  in  1  asynchronous, active-high reset.
- s_data_i  in  8  input byte.
- s_valid_i  in  1  input byte valid.
- s_last_i  in  1  final byte of message; qualified by s_valid_i.
- s_ready_o  out  1  packer can accept a byte.
- data_o  out  32  packed word, to checker data_i.
- data_valid_o  out  1  word valid, to checker data_valid_i.
- data_last_o  out  1  final word of message, to checker data_last_i.
- msg_len_o  out  6  bytes in the message (1..32); valid only while data_last_o is high.
- overflow_o  out  1  one-cycle pulse with data_last_o when the message exceeded capacity.

Behaviour:
- Reset (asynchronous, active-high):
  - Outputs: data_o=0, data_valid_o=0, data_last_o=0, msg_len_o=0, overflow_o=0, s_ready_o=0.
  - Internals: state=COLLECT, byte lane=0, word counter=0, byte count=0, gap counter=0.
  - s_ready_o goes high the first cycle after rst_i deasserts.
  - Reset mid-message discards everything; no partial word is emitted.
- Byte acceptance: only when s_valid_i && s_ready_o. s_valid_i without s_ready_o has no effect.
- Byte lanes: lane n occupies data_o[8n+7:8n]. The first byte of a word goes to [7:0].
- Outputs are registered. data_valid_o and data_last_o are single-cycle and never back-pressured, because the checker has no ready.
- Latency: a byte accepted in cycle k that completes a word (lane 3, or s_last_i) produces data_valid_o=1 in cycle k+1.
- States:
  - COLLECT (s_ready_o=1)
    - Accumulate bytes into lanes.
    - Full word with word counter < WORDS_PER_MSG-1: emit the word, increment the word counter.
    - Last byte: fill the remaining lanes with PAD_BYTE and emit. If this word was the final word, assert data_last_o and go to GAP; otherwise go to PAD.
    - Capacity byte (4*WORDS_PER_MSG-th) accepted without s_last_i: emit the word with data_last_o=1, pulse overflow_o, msg_len_o=32, go to DROP.
    - Capacity byte accepted with s_last_i: normal last, no overflow, go to GAP.
  - PAD (s_ready_o=0)
    - Emit one word of {4{PAD_BYTE}} per cycle until word counter = WORDS_PER_MSG-1.
    - That final word carries data_last_o=1; then go to GAP.
  - DROP (s_ready_o=1)
    - Accept and discard bytes; no output.
    - On the accepted byte with s_last_i, go to GAP.
  - GAP (s_ready_o=0)
    - Count GAP_CYCLES cycles starting the cycle after data_last_o (or the cycle after the last byte is accepted in DROP), then go to COLLECT with lane=0, word counter=0, byte count=0.
    - GAP_CYCLES=0 returns to COLLECT immediately.
- msg_len_o: 6-bit count of accepted bytes, saturating at 32 (DROP bytes not counted). Encoded 6'd32 for a full message. Held at 0 when data_last_o=0.
- Word counter is 3 bits, sized clog2(WORDS_PER_MSG). It never wraps inside a message; it is reset on GAP exit.
- Bubbles in s_valid_i are allowed anywhere in COLLECT/DROP. They stall assembly and produce no output.
- data_valid_o is never high in two different messages without at least GAP_CYCLES low cycles between them.

Decomposition:
- Shared package crc_pkg:
  - Packer state enum {COLLECT, PAD, DROP, GAP}.
  - WORD_W=32, BYTE_W=8, CRC_MSG_WORDS=8, CRC_MSG_BYTES=32.
  - Default PAD_BYTE.
- The checker also uses CRC_MSG_WORDS from this package.
- Sub-module crc_word_assembler: lane shift/fill logic.
  - Inputs: byte, lane, pad enable.
  - Outputs: assembled word, word-complete.
  - The top-level module holds the FSM, counters and output registers.

Test Plan:
- 32 bytes 0x00..0x1F, continuous valid, last on 0x1F → 8 consecutive words 0x03020100 .. 0x1F1E1D1C; data_last_o on word 8; msg_len_o=32; overflow_o=0; then s_ready_o low 3 cycles.
- 5 bytes 0x00..0x04, last on 0x04 → words 0x03020100, 0x00000004, then six 0x00000000; last on the 8th; msg_len_o=5; s_ready_o low from the byte after last until GAP ends.
- 40 bytes, last on byte 40 → 8 words ending 0x1F1E1D1C with data_last_o=1, overflow_o=1, msg_len_o=32; bytes 33..40 accepted with no data_valid_o; then 3-cycle gap.
- Random s_valid_i bubbles (50%) on a 12-byte message → same word values as the no-bubble run; each word appears one cycle after its 4th byte is accepted; 8 words total.
- Back-to-back messages with s_valid_i held high → second message's first byte accepted exactly GAP_CYCLES+1 cycles after the first data_last_o; checker crc_valid_o fires once per message.
- Assert rst_i asynchronously during PAD (after word 3) → all outputs 0 immediately; no data_last_o; next 4-byte message emits a clean 8-word block starting at word 0.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared definitions for the CRC32 message path (packer and checker).
package crc_pkg;

  localparam int unsigned WORD_W        = 32;
  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned CRC_MSG_WORDS = 8;
  localparam int unsigned CRC_MSG_BYTES = 32;

  localparam logic [BYTE_W-1:0] CRC_PAD_BYTE = 8'h00;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    PAD     = 2'd1,
    DROP    = 2'd2,
    GAP     = 2'd3
  } packer_state_e;

endpackage

// File: rtl/crc_word_assembler.sv
// Little-endian byte lane merge: places the incoming byte in its lane on top of the
// lanes already collected, and optionally fills the higher lanes with the pad byte.
module crc_word_assembler
  import crc_pkg::*;
#(
  parameter logic [BYTE_W-1:0] PAD_BYTE = CRC_PAD_BYTE
) (
  input  logic [BYTE_W-1:0] i_byte,
  input  logic [1:0]        i_lane,
  input  logic              i_pad,
  input  logic [WORD_W-1:0] i_partial,
  output logic [WORD_W-1:0] o_word,
  output logic              o_complete
);

  localparam int unsigned Lanes = WORD_W / BYTE_W;

  // Lanes below the current one come from the partial word, lanes above are pad or zero.
  always_comb begin
    o_word = '0;
    for (int n = 0; n < Lanes; n++) begin
      if (2'(n) < i_lane) begin
        o_word[n*BYTE_W +: BYTE_W] = i_partial[n*BYTE_W +: BYTE_W];
      end else if (2'(n) == i_lane) begin
        o_word[n*BYTE_W +: BYTE_W] = i_byte;
      end else if (i_pad) begin
        o_word[n*BYTE_W +: BYTE_W] = PAD_BYTE;
      end
    end
  end

  assign o_complete = (i_lane == 2'd3) || i_pad;

endmodule

// File: rtl/crc_msg_packer.sv
// Byte-stream to fixed-size word-block packer feeding the CRC32 checker. Every message
// becomes exactly WORDS_PER_MSG words, then an idle gap lets the checker drain.
module crc_msg_packer
  import crc_pkg::*;
#(
  parameter int unsigned       WORDS_PER_MSG = CRC_MSG_WORDS,
  parameter int unsigned       GAP_CYCLES    = 3,
  parameter logic [BYTE_W-1:0] PAD_BYTE      = CRC_PAD_BYTE
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [BYTE_W-1:0] s_data_i,
  input  logic              s_valid_i,
  input  logic              s_last_i,
  output logic              s_ready_o,
  output logic [WORD_W-1:0] data_o,
  output logic              data_valid_o,
  output logic              data_last_o,
  output logic [5:0]        msg_len_o,
  output logic              overflow_o
);

  localparam int unsigned WordCntW = (WORDS_PER_MSG > 1) ? $clog2(WORDS_PER_MSG) : 1;
  localparam int unsigned GapW     = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [WordCntW-1:0] LastWord    = WordCntW'(WORDS_PER_MSG - 1);
  localparam logic [GapW-1:0]     GapLoad     = GapW'(GAP_CYCLES);
  // The drop path starts its gap one cycle earlier (no data_last cycle precedes it).
  localparam logic [GapW-1:0]     GapLoadDrop = (GAP_CYCLES > 0) ? GapW'(GAP_CYCLES - 1) : '0;
  localparam logic [5:0]          MaxLen      = 6'(CRC_MSG_BYTES);

  localparam logic [1:0] S_COLLECT = COLLECT;
  localparam logic [1:0] S_PAD     = PAD;
  localparam logic [1:0] S_DROP    = DROP;
  localparam logic [1:0] S_GAP     = GAP;

  logic [1:0]          r_state, w_state_n;
  logic [1:0]          r_lane, w_lane_n;
  logic [WordCntW-1:0] r_word, w_word_n;
  logic [5:0]          r_bytes, w_bytes_n;
  logic [GapW-1:0]     r_gap, w_gap_n;
  logic [WORD_W-1:0]   r_partial, w_partial_n;
  logic                r_ready, w_ready_n;
  logic [WORD_W-1:0]   r_data, w_data_n;
  logic                r_valid, w_valid_n;
  logic                r_last, w_last_n;
  logic [5:0]          r_len, w_len_n;
  logic                r_ovf, w_ovf_n;

  logic              w_accept;
  logic              w_final_word;
  logic [5:0]        w_bytes_inc;
  logic [WORD_W-1:0] w_asm_word;
  logic              w_asm_complete;

  assign w_accept     = s_valid_i && r_ready;
  assign w_final_word = (r_word == LastWord);
  assign w_bytes_inc  = (r_bytes == MaxLen) ? r_bytes : r_bytes + 6'd1;

  crc_word_assembler #(
    .PAD_BYTE (PAD_BYTE)
  ) u_asm (
    .i_byte     (s_data_i),
    .i_lane     (r_lane),
    .i_pad      (s_last_i),
    .i_partial  (r_partial),
    .o_word     (w_asm_word),
    .o_complete (w_asm_complete)
  );

  // Next-state, counter and registered-output decode.
  always_comb begin
    w_state_n   = r_state;
    w_lane_n    = r_lane;
    w_word_n    = r_word;
    w_bytes_n   = r_bytes;
    w_gap_n     = r_gap;
    w_partial_n = r_partial;
    w_data_n    = r_data;
    w_valid_n   = 1'b0;
    w_last_n    = 1'b0;
    w_len_n     = '0;
    w_ovf_n     = 1'b0;

    case (r_state)
      S_COLLECT: begin
        if (w_accept) begin
          w_bytes_n = w_bytes_inc;
          if (w_asm_complete) begin
            w_data_n    = w_asm_word;
            w_valid_n   = 1'b1;
            w_lane_n    = '0;
            w_partial_n = '0;
            if (s_last_i) begin
              if (w_final_word) begin
                w_last_n  = 1'b1;
                w_len_n   = w_bytes_inc;
                w_state_n = S_GAP;
                w_gap_n   = GapLoad;
              end else begin
                w_word_n  = r_word + 1'b1;
                w_state_n = S_PAD;
              end
            end else if (w_final_word) begin
              // Capacity reached without last: close the block, discard the rest.
              w_last_n  = 1'b1;
              w_ovf_n   = 1'b1;
              w_len_n   = w_bytes_inc;
              w_state_n = S_DROP;
            end else begin
              w_word_n = r_word + 1'b1;
            end
          end else begin
            w_lane_n    = r_lane + 2'd1;
            w_partial_n = w_asm_word;
          end
        end
      end

      S_PAD: begin
        w_data_n  = {(WORD_W / BYTE_W){PAD_BYTE}};
        w_valid_n = 1'b1;
        if (w_final_word) begin
          w_last_n  = 1'b1;
          w_len_n   = r_bytes;
          w_state_n = S_GAP;
          w_gap_n   = GapLoad;
        end else begin
          w_word_n = r_word + 1'b1;
        end
      end

      S_DROP: begin
        if (w_accept && s_last_i) begin
          if (GAP_CYCLES == 0) begin
            w_state_n   = S_COLLECT;
            w_lane_n    = '0;
            w_word_n    = '0;
            w_bytes_n   = '0;
            w_partial_n = '0;
          end else begin
            w_state_n = S_GAP;
            w_gap_n   = GapLoadDrop;
          end
        end
      end

      default: begin
        if (r_gap == '0) begin
          w_state_n   = S_COLLECT;
          w_lane_n    = '0;
          w_word_n    = '0;
          w_bytes_n   = '0;
          w_partial_n = '0;
        end else begin
          w_gap_n = r_gap - 1'b1;
        end
      end
    endcase

    w_ready_n = (w_state_n == S_COLLECT) || (w_state_n == S_DROP);
  end

  // State and output registers; reset discards any partially built message.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= S_COLLECT;
      r_lane    <= '0;
      r_word    <= '0;
      r_bytes   <= '0;
      r_gap     <= '0;
      r_partial <= '0;
      r_ready   <= 1'b0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_len     <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_lane    <= w_lane_n;
      r_word    <= w_word_n;
      r_bytes   <= w_bytes_n;
      r_gap     <= w_gap_n;
      r_partial <= w_partial_n;
      r_ready   <= w_ready_n;
      r_data    <= w_data_n;
      r_valid   <= w_valid_n;
      r_last    <= w_last_n;
      r_len     <= w_len_n;
      r_ovf     <= w_ovf_n;
    end
  end

  assign s_ready_o    = r_ready;
  assign data_o       = r_data;
  assign data_valid_o = r_valid;
  assign data_last_o  = r_last;
  assign msg_len_o    = r_len;
  assign overflow_o   = r_ovf;

endmodule

// File: tb/tb_crc_msg_packer.sv
// Scoreboard bench for crc_msg_packer: the driver predicts every word (value, flags and
// arrival cycle) when bytes are accepted; a negedge monitor pops and compares.
module tb_crc_msg_packer;

  localparam int WORDS = 8;
  localparam int GAP   = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready_o;
  logic [31:0] data_o;
  logic        data_valid_o;
  logic        data_last_o;
  logic [5:0]  msg_len_o;
  logic        overflow_o;

  crc_msg_packer #(
    .WORDS_PER_MSG (WORDS),
    .GAP_CYCLES    (GAP),
    .PAD_BYTE      (8'h00)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .s_data_i     (s_data),
    .s_valid_i    (s_valid),
    .s_last_i     (s_last),
    .s_ready_o    (s_ready_o),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .data_last_o  (data_last_o),
    .msg_len_o    (msg_len_o),
    .overflow_o   (overflow_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [5:0]  len;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   words_seen = 0;
  int   total = 0;
  int   bad = 0;
  int   nxt;
  int   base;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [31:0] d, input logic l, input logic [5:0] n,
                          input logic o, input int c);
    exp_t e;
    e.data = d; e.last = l; e.len = n; e.ovf = o; e.cyc = c;
    q.push_back(e);
  endtask

  // Monitor: every output word must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (data_valid_o) begin
        if (q.size() == 0) begin
          chk("unexpected_word", {data_o, data_last_o, overflow_o}, 64'h0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("word_data", data_o, e.data);
          chk("word_flags", {data_last_o, overflow_o, msg_len_o}, {e.last, e.ovf, e.len});
          chk("word_cycle", cyc, e.cyc);
          words_seen++;
        end
      end else begin
        chk("idle_flags", {data_last_o, overflow_o, msg_len_o}, 64'h0);
      end
    end
  end

  // Present one byte from a negedge; returns the cycle in which it was accepted.
  task automatic drive_byte(input logic [7:0] b, input logic l, output int acc);
    int n = 0;
    s_data = b; s_last = l; s_valid = 1'b1;
    while (!s_ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", s_ready_o, 1);
    acc = cyc;
    @(negedge clk);
  endtask

  // Send bytes 0..n-1 and predict the packed block. exp_first >= 0 checks the cycle
  // of the first acceptance; next_first returns the predicted earliest next acceptance.
  task automatic send_msg(input int n, input bit bubbles, input int exp_first,
                          output int next_first);
    logic [31:0] wb = '0;
    int acc = 0;
    int lane, w, k;
    next_first = -1;
    for (int i = 0; i < n; i++) begin
      if (bubbles && i > 0) begin
        k = 0;
        while (k < 3 && $urandom_range(1, 0) == 1) begin
          s_valid = 1'b0;
          @(negedge clk);
          k++;
        end
      end
      drive_byte(8'(i), (i == n - 1), acc);
      if (i == 0 && exp_first >= 0) chk("first_accept_cycle", acc, exp_first);
      lane = i % 4;
      w    = i / 4;
      if (i < 32) begin
        wb[lane*8 +: 8] = 8'(i);
        if (i == n - 1) begin
          push_exp(wb, (w == WORDS - 1), (w == WORDS - 1) ? 6'(n) : 6'd0, 1'b0, acc + 1);
          for (int p = w + 1; p < WORDS; p++)
            push_exp(32'h0, (p == WORDS - 1), (p == WORDS - 1) ? 6'(n) : 6'd0, 1'b0,
                     acc + 1 + (p - w));
          next_first = acc + 1 + (WORDS - 1 - w) + GAP + 1;
          wb = '0;
        end else if (lane == 3) begin
          push_exp(wb, (w == WORDS - 1), (w == WORDS - 1) ? 6'd32 : 6'd0, (w == WORDS - 1),
                   acc + 1);
          wb = '0;
        end
      end else if (i == n - 1) begin
        next_first = acc + GAP + 1;
      end
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("queue_drained", q.size(), 0);
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {data_o, data_valid_o, data_last_o, msg_len_o, overflow_o, s_ready_o},
        64'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", s_ready_o, 1);

    // Full, short (padded), overflow and bubbled messages back to back.
    send_msg(32, 1'b0, -1, nxt);
    send_msg(5, 1'b0, nxt, nxt);
    send_msg(40, 1'b0, nxt, nxt);
    send_msg(12, 1'b1, nxt, nxt);
    s_valid = 1'b0;
    @(negedge clk);
    wait_drain();

    // Asynchronous reset in the middle of the pad words.
    base = words_seen;
    send_msg(5, 1'b0, -1, nxt);
    s_valid = 1'b0;
    for (int n = 0; n < 50 && words_seen < base + 4; n++) begin
      @(negedge clk);
      #1;
    end
    chk("words_before_reset", words_seen, base + 4);
    #1 rst = 1'b1;
    #1 chk("async_reset_outputs",
           {data_o, data_valid_o, data_last_o, msg_len_o, overflow_o, s_ready_o}, 64'h0);
    q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    send_msg(4, 1'b0, -1, nxt);
    s_valid = 1'b0;
    wait_drain();
    repeat (8) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
